led7s_scan: RTL and testbench

Time-multiplexed scan driver for a DIGITS-digit common-bus 7-segment display; sits directly upstream of the LED7S hex decoder. Holds a double-buffered digit store written by the host and cycles one digit at a time, presenting its 4-bit code on A (to LED7S), a one-hot digit select, and a blank flag. Buffer swaps occur only at frame boundaries, so the display never tears.

---
 rtl/led7s_scan_pkg.sv | 12 +
 rtl/led7s_scan_prescaler.sv | 36 +++
 rtl/led7s_scan.sv | 117 +++++++++++
 tb/tb_led7s_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/led7s_scan_pkg.sv
// led7s_scan_pkg
// Shared constants for the 7-segment scan driver: digit code width,
// largest supported digit count, default prescale divider and the code
// every digit store holds after reset.
package led7s_scan_pkg;

  localparam int          DIGIT_W     = 4;
  localparam int          MAX_DIGITS  = 8;
  localparam int          DEFAULT_DIV = 50000;
  localparam logic [3:0]  RESET_CODE  = 4'h0;

endpackage

// File: rtl/led7s_scan_prescaler.sv
// led7s_prescaler
// Divides clk_i down to one tick_o pulse every DIV cycles. The counter
// runs 0..DIV-1 and the tick is the terminal-count compare, so DIV=1
// degenerates to a counter stuck at 0 with tick_o high every cycle.
//
// Ports
//   clk_i   system clock, rising edge
//   rst_i   synchronous active-high reset (counter back to 0)
//   tick_o  high during the last cycle of each DIV-cycle slot
module led7s_prescaler
  import led7s_scan_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  assign tick_o = (pcnt_q == CNT_W'(DIV - 1));

  always_comb begin
    pcnt_d = pcnt_q + CNT_W'(1);
    if (tick_o) pcnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/led7s_scan.sv
// led7s_scan
// Time-multiplexed scan driver for a DIGITS-digit common-bus 7-segment
// display. The host writes a shadow buffer; an update request copies the
// shadow into the live buffer only on the frame-wrap tick, so a frame is
// never shown half old / half new. One digit is presented per DIV cycles.
//
// Optional feature macro: LED7S_ZERO_BLANK_EN (leading-zero suppression
// on blank_o). Without it blank_o is tied low.
//
// Ports
//   clk_i     system clock
//   rst_i     synchronous active-high reset, overrides we_i/update_i
//   we_i      shadow write strobe
//   waddr_i   shadow digit index, 0 = rightmost; >= DIGITS ignored
//   wdata_i   hex code written
//   update_i  request shadow->live copy at the next frame wrap
//   a_o       code of the selected digit
//   sel_o     one-hot digit select
//   blank_o   current digit must be dark
//   frame_o   one-cycle pulse after the edge that loaded the live buffer
module led7s_scan
  import led7s_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = DEFAULT_DIV
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [2:0]          waddr_i,
  input  logic [DIGIT_W-1:0]  wdata_i,
  input  logic                update_i,
  output logic [DIGIT_W-1:0]  a_o,
  output logic [DIGITS-1:0]   sel_o,
  output logic                blank_o,
  output logic                frame_o
);

  localparam int IDX_W = $clog2(DIGITS);

  logic                tick;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pend_q, pend_d;
  logic                frame_q, frame_d;
  logic [DIGIT_W-1:0]  shadow_q [DIGITS];
  logic [DIGIT_W-1:0]  shadow_d [DIGITS];
  logic [DIGIT_W-1:0]  live_q   [DIGITS];
  logic [DIGIT_W-1:0]  live_d   [DIGITS];
  logic                wrap;
  logic                copy;

  led7s_prescaler #(.DIV(DIV)) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));
  // An update arriving on the wrap tick itself is consumed by that copy.
  assign copy = wrap && (pend_q || update_i);

  always_comb begin
    idx_d    = idx_q;
    pend_d   = pend_q || update_i;
    frame_d  = copy;
    shadow_d = shadow_q;
    live_d   = live_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    if (wrap) pend_d = 1'b0;
    // live takes the pre-write shadow; a coincident write lands in shadow only.
    if (copy) live_d = shadow_q;
    if (we_i && (int'(waddr_i) < DIGITS)) shadow_d[waddr_i[IDX_W-1:0]] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
        shadow_q[k] <= RESET_CODE;
        live_q[k]   <= RESET_CODE;
      end
    end else begin
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  assign a_o     = live_q[idx_q];
  assign sel_o   = DIGITS'(1) << idx_q;
  assign frame_o = frame_q;

`ifdef LED7S_ZERO_BLANK_EN
  // Walk from the top digit down accumulating "everything from here up is
  // zero"; digit 0 is excluded so an all-zero value still shows "0".
  logic blank;
  logic zero_run;

  always_comb begin
    blank    = 1'b0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (live_q[k] == RESET_CODE);
      if (idx_q == IDX_W'(k)) blank = zero_run;
    end
  end

  assign blank_o = blank;
`else
  assign blank_o = 1'b0;
`endif

endmodule

// File: tb/tb_led7s_scan.sv
module tb_led7s_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [3:0]  wdata = '0;
  logic        upd = 1'b0;

  logic [3:0]        a, a2;
  logic [DIGITS-1:0] sel, sel2;
  logic              blank, blank2, frame, frame2;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: time since reset plus buffer contents
  int cyc;
  int m_sh [DIGITS];
  int m_lv [DIGITS];
  bit m_pend;
  bit m_frame;

  always #5 clk = ~clk;

  led7s_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .update_i(upd), .a_o(a), .sel_o(sel), .blank_o(blank), .frame_o(frame)
  );

  led7s_scan #(.DIGITS(DIGITS), .DIV(1)) dut_fast (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .update_i(upd), .a_o(a2), .sel_o(sel2), .blank_o(blank2), .frame_o(frame2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic int exp_blank(input int idx);
`ifdef LED7S_ZERO_BLANK_EN
    if (idx == 0) return 0;
    for (int k = idx; k < DIGITS; k++) if (m_lv[k] != 0) return 0;
    return 1;
`else
    return 0;
`endif
  endfunction

  task automatic step(input bit r, input bit w, input int ad, input int d, input bit u);
    bit wrap, copy;
    int idx, idx2;
    rst = r; we = w; waddr = ad[2:0]; wdata = d[3:0]; upd = u;
    @(posedge clk);
    if (r) begin
      cyc = 0; m_pend = 0; m_frame = 0;
      for (int k = 0; k < DIGITS; k++) begin m_sh[k] = 0; m_lv[k] = 0; end
    end else begin
      wrap = ((cyc + 1) % (DIV * DIGITS)) == 0;
      copy = wrap && (m_pend || u);
      if (copy) for (int k = 0; k < DIGITS; k++) m_lv[k] = m_sh[k];
      m_frame = copy;
      m_pend  = wrap ? 1'b0 : (m_pend || u);
      if (w && ad < DIGITS) m_sh[ad] = d;
      cyc++;
    end
    #1;
    idx  = (cyc / DIV) % DIGITS;
    idx2 = cyc % DIGITS;
    check("a",     32'(a),     32'(m_lv[idx]));
    check("sel",   32'(sel),   32'(1 << idx));
    check("blank", 32'(blank), 32'(exp_blank(idx)));
    check("frame", 32'(frame), 32'(m_frame));
    check("sel_div1", 32'(sel2), 32'(1 << idx2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc = 0;
    // reset with write/update activity that must be ignored
    for (int i = 0; i < 3; i++) step(1, (i % 2) == 0, i, 4'hA, (i % 2) == 1);
    idle(20);

    // basic scan: 1,2,3,4 at digits 0..3
    for (int i = 0; i < DIGITS; i++) step(0, 1, i, i + 1, 0);
    step(0, 0, 0, 0, 1);
    idle(40);

    // tear-free: update issued while digit 1 is shown
    for (int i = 0; i < 16; i++) begin
      if (((cyc / DIV) % DIGITS) == 1) break;
      idle(1);
    end
    step(0, 1, 0, 5, 1);
    for (int i = 1; i < DIGITS; i++) step(0, 1, i, i + 5, 0);
    idle(24);

    // collision: write digit 0 on the copy edge
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      if (((cyc + 1) % (DIV * DIGITS)) == 0) break;
      idle(1);
    end
    step(0, 1, 0, 9, 0);
    idle(20);
    step(0, 0, 0, 0, 1);
    idle(20);

    // out-of-range addresses
    step(0, 1, 5, 15, 0);
    step(0, 1, 7, 14, 0);
    step(0, 0, 0, 0, 1);
    idle(20);

    // leading-zero patterns: 0,0,7,0 (addr3..0), then all zero
    for (int i = 0; i < DIGITS; i++) step(0, 1, i, (i == 1) ? 7 : 0, 0);
    step(0, 0, 0, 0, 1);
    idle(20);
    for (int i = 0; i < DIGITS; i++) step(0, 1, i, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(20);

    // update requested on the wrap tick itself
    step(0, 1, 2, 3, 0);
    for (int i = 0; i < 16; i++) begin
      if (((cyc + 1) % (DIV * DIGITS)) == 0) break;
      idle(1);
    end
    step(0, 0, 0, 0, 1);
    idle(18);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, 15), $urandom_range(0, 15) == 0);

    // mid-frame reset with a pending update
    step(0, 1, 3, 12, 1);
    idle(5);
    step(1, 0, 0, 0, 0);
    idle(24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
